// File: rtl/rc4_phase_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : rc4_phase_sequencer_if
// Brief    : Handshake bundle between the RC4 phase sequencer and its datapath.
//            Timeout signals exist only when PHASE_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface rc4_phase_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int KEY_W      = 24,
  parameter int SEL_W      = $clog2(NUM_PHASES + 1)
);
  logic                  go;
  logic                  abort;
  logic [NUM_PHASES-1:0] phase_finish;
  logic                  pass_ok;
  logic [NUM_PHASES-1:0] phase_start;
  logic [SEL_W-1:0]      mem_sel;
  logic [KEY_W-1:0]      key;
  logic                  busy;
  logic                  done;
  logic                  found;
  logic                  exhausted;
`ifdef PHASE_TIMEOUT_EN
  logic                  timeout;
  logic [SEL_W-1:0]      err_phase;
`endif

  modport master (
    input  go, abort, phase_finish, pass_ok,
    output phase_start, mem_sel, key, busy, done, found, exhausted
`ifdef PHASE_TIMEOUT_EN
    , output timeout, err_phase
`endif
  );

  modport slave (
    output go, abort, phase_finish, pass_ok,
    input  phase_start, mem_sel, key, busy, done, found, exhausted
`ifdef PHASE_TIMEOUT_EN
    , input timeout, err_phase
`endif
  );
endinterface
`default_nettype wire

// File: rtl/rc4_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rc4_phase_sequencer
// Brief    : Steps the RC4 sub-blocks in order and runs the key-search loop.
//            Optional macro PHASE_TIMEOUT_EN adds a per-WAIT watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module rc4_phase_sequencer #(
  parameter int               NUM_PHASES     = 4,
  parameter int               RESTART_PHASE  = 0,
  parameter int               KEY_W          = 24,
  parameter logic [KEY_W-1:0] KEY_MIN        = '0,
  parameter logic [KEY_W-1:0] KEY_MAX        = '1,
  parameter int               TIMEOUT_CYCLES = 65535,
  parameter int               SEL_W          = $clog2(NUM_PHASES + 1)
) (
  input  wire                    clk,
  input  wire                    rst,
  rc4_phase_sequencer_if.master  bus
);

  localparam int                    c_ph_w       = $clog2(NUM_PHASES);
  localparam logic [c_ph_w-1:0]     c_last_phase = c_ph_w'(NUM_PHASES - 1);
  localparam logic [c_ph_w-1:0]     c_restart    = c_ph_w'(RESTART_PHASE);
  localparam logic [NUM_PHASES-1:0] c_one_hot0   = NUM_PHASES'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  logic [c_ph_w-1:0] r_phase;
  logic [KEY_W-1:0]  r_key;
  logic              r_found;
  logic              r_exhausted;
  logic              w_finish;
  logic [SEL_W-1:0]  w_active_sel;

  // Only the active phase's finish is looked at; other bits are don't-care.
  assign w_finish     = bus.phase_finish[r_phase];
  assign w_active_sel = SEL_W'(r_phase) + SEL_W'(1);

  assign bus.phase_start = (r_state == ST_START) ? (c_one_hot0 << r_phase) : '0;
  assign bus.mem_sel     = (r_state == ST_WAIT) ? w_active_sel : '0;
  assign bus.key         = r_key;
  assign bus.busy        = (r_state == ST_START) || (r_state == ST_WAIT) || (r_state == ST_CHECK);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.found       = r_found;
  assign bus.exhausted   = r_exhausted;

`ifdef PHASE_TIMEOUT_EN
  localparam int               c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

  logic [c_to_w-1:0] r_wait_cnt;
  logic              r_timeout;
  logic [SEL_W-1:0]  r_err_phase;

  assign bus.timeout   = r_timeout;
  assign bus.err_phase = r_err_phase;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_key       <= KEY_MIN;
      r_found     <= 1'b0;
      r_exhausted <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_err_phase <= '0;
`endif
    end else if (bus.abort) begin
      // Abort wins over go and finish; the key is deliberately kept.
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_found     <= 1'b0;
      r_exhausted <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
      r_timeout   <= 1'b0;
      r_err_phase <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.go) begin
            r_state     <= ST_START;
            r_phase     <= '0;
            r_key       <= KEY_MIN;
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
            r_timeout   <= 1'b0;
            r_err_phase <= '0;
`endif
          end
        end
        ST_START: begin
          r_state <= ST_WAIT;
`ifdef PHASE_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (w_finish) begin
            if (r_phase == c_last_phase) begin
              r_state <= ST_CHECK;
            end else begin
              r_phase <= r_phase + c_ph_w'(1);
              r_state <= ST_START;
            end
          end
`ifdef PHASE_TIMEOUT_EN
          else if (r_wait_cnt == c_to_last) begin
            r_state     <= ST_DONE;
            r_timeout   <= 1'b1;
            r_err_phase <= w_active_sel;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_to_w'(1);
          end
`endif
        end
        ST_CHECK: begin
          if (bus.pass_ok) begin
            r_state <= ST_DONE;
            r_found <= 1'b1;
          end else if (r_key == KEY_MAX) begin
            r_state     <= ST_DONE;
            r_exhausted <= 1'b1;
          end else begin
            r_key   <= r_key + KEY_W'(1);
            r_phase <= c_restart;
            r_state <= ST_START;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rc4_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc4_phase_sequencer
// Brief    : Directed self-checking bench for rc4_phase_sequencer
//            (NUM_PHASES=4, KEY_MIN=0, KEY_MAX=3, TIMEOUT_CYCLES=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rc4_phase_sequencer;

  localparam int NP = 4;
  localparam int KW = 24;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rc4_phase_sequencer_if #(.NUM_PHASES(NP), .KEY_W(KW)) bus ();

  rc4_phase_sequencer #(
    .NUM_PHASES     (NP),
    .RESTART_PHASE  (0),
    .KEY_W          (KW),
    .KEY_MIN        (24'd0),
    .KEY_MAX        (24'd3),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks;
  int          n_errors;
  logic        auto_en;
  logic [NP-1:0] auto_finish;
  logic [NP-1:0] man_finish;
  logic [3:0]  pass_mask;
  int          fin_cnt [NP];
  int          start_log [$];
  int          sel_log [$];
  logic [NP-1:0] prev_start;
  logic [SW-1:0] prev_sel;
  int          cyc;

  assign bus.phase_finish = auto_en ? auto_finish : man_finish;
  assign bus.pass_ok      = pass_mask[bus.key[1:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] encode(input int q[$]);
    logic [63:0] r;
    r = '0;
    foreach (q[i]) r = (r << 4) | 64'(q[i]);
    return r;
  endfunction

  // Datapath model: each phase raises its finish 3 cycles after its start.
  always @(negedge clk) begin
    if (rst) begin
      auto_finish = '0;
      for (int p = 0; p < NP; p++) fin_cnt[p] = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (bus.phase_start[p]) begin
          auto_finish[p] = 1'b0;
          fin_cnt[p]     = 3;
        end else if (fin_cnt[p] > 0) begin
          fin_cnt[p]--;
          if (fin_cnt[p] == 0) auto_finish[p] = 1'b1;
        end
      end
    end
  end

  // Start-pulse / mem_sel monitor.
  always @(negedge clk) begin
    if (!rst && bus.phase_start != '0) begin
      check("start_onehot", 64'($onehot(bus.phase_start)), 64'd1);
      check("start_memsel", 64'(bus.mem_sel), 64'd0);
      check("start_1cyc", 64'(bus.phase_start == prev_start), 64'd0);
      for (int p = 0; p < NP; p++) if (bus.phase_start[p]) start_log.push_back(p);
    end
    if (!rst && bus.mem_sel != '0 && bus.mem_sel != prev_sel) sel_log.push_back(int'(bus.mem_sel));
    prev_start = bus.phase_start;
    prev_sel   = bus.mem_sel;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_log.delete();
    sel_log.delete();
  endtask

  task automatic pulse_go();
    start_log.delete();
    sel_log.delete();
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    check("go_latency", 64'(bus.phase_start), 64'h1);
  endtask

  task automatic wait_done(output int n, input int limit);
    n = 0;
    while (!bus.done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 64'(bus.done), 64'd1);
  endtask

  task automatic wait_sel_key(input int sel, input int k, input int limit);
    int n;
    n = 0;
    while (!(bus.mem_sel == SW'(sel) && bus.key == KW'(k)) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait", 64'(bus.mem_sel == SW'(sel) && bus.key == KW'(k)), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    bus.go     = 1'b0;
    bus.abort  = 1'b0;
    auto_en    = 1'b1;
    man_finish = '0;
    pass_mask  = 4'hF;
    prev_start = '0;
    prev_sel   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_start", 64'(bus.phase_start), 64'd0);
    check("rst_memsel", 64'(bus.mem_sel), 64'd0);
    check("rst_key", 64'(bus.key), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_found", 64'(bus.found), 64'd0);
    check("rst_exh", 64'(bus.exhausted), 64'd0);
    do_reset();

    // 1: first key passes
    pulse_go();
    wait_done(cyc, 200);
    check("t1_cycles", 64'(cyc), 64'd17);
    check("t1_starts", encode(start_log), 64'h0123);
    check("t1_sels", encode(sel_log), 64'h1234);
    check("t1_found", 64'(bus.found), 64'd1);
    check("t1_exh", 64'(bus.exhausted), 64'd0);
    check("t1_key", 64'(bus.key), 64'd0);
    check("t1_busy", 64'(bus.busy), 64'd0);

    // 2: key 2 passes, restart from DONE
    pass_mask = 4'b0100;
    pulse_go();
    check("t2_found_clr", 64'(bus.found), 64'd0);
    wait_done(cyc, 300);
    check("t2_cycles", 64'(cyc), 64'd51);
    check("t2_starts", encode(start_log), 64'h0123_0123_0123);
    check("t2_found", 64'(bus.found), 64'd1);
    check("t2_exh", 64'(bus.exhausted), 64'd0);
    check("t2_key", 64'(bus.key), 64'd2);

    // 3: every key fails, no wrap
    pass_mask = 4'b0000;
    pulse_go();
    wait_done(cyc, 300);
    check("t3_cycles", 64'(cyc), 64'd68);
    check("t3_nstarts", 64'(start_log.size()), 64'd16);
    check("t3_found", 64'(bus.found), 64'd0);
    check("t3_exh", 64'(bus.exhausted), 64'd1);
    check("t3_key", 64'(bus.key), 64'd3);
    @(negedge clk);
    check("t3_key_hold", 64'(bus.key), 64'd3);

    // 4: stale and foreign finish bits
    auto_en    = 1'b0;
    man_finish = 4'b0010;
    pass_mask  = 4'hF;
    do_reset();
    pulse_go();
    man_finish = 4'b0110;
    repeat (3) @(negedge clk);
    check("t4_p0_hold", 64'(bus.mem_sel), 64'd1);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    check("t4_go_ignored", 64'(bus.mem_sel), 64'd1);
    man_finish = 4'b0111;
    @(negedge clk);
    check("t4_p1_start", 64'(bus.phase_start), 64'b0010);
    man_finish = 4'b1111;
    wait_done(cyc, 100);
    check("t4_starts", encode(start_log), 64'h0123);
    check("t4_sels", encode(sel_log), 64'h1234);
    check("t4_found", 64'(bus.found), 64'd1);

    // 5: abort, go+abort, go; then reset mid-WAIT
    auto_en    = 1'b1;
    man_finish = '0;
    pass_mask  = 4'b0000;
    do_reset();
    pulse_go();
    wait_sel_key(3, 1, 200);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("t5_ab_busy", 64'(bus.busy), 64'd0);
    check("t5_ab_done", 64'(bus.done), 64'd0);
    check("t5_ab_memsel", 64'(bus.mem_sel), 64'd0);
    check("t5_ab_start", 64'(bus.phase_start), 64'd0);
    check("t5_ab_found", 64'(bus.found), 64'd0);
    check("t5_ab_key", 64'(bus.key), 64'd1);
    bus.go    = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.go    = 1'b0;
    bus.abort = 1'b0;
    check("t5_ga_busy", 64'(bus.busy), 64'd0);
    check("t5_ga_start", 64'(bus.phase_start), 64'd0);
    pulse_go();
    check("t5_go_key", 64'(bus.key), 64'd0);
    wait_sel_key(3, 1, 200);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_busy", 64'(bus.busy), 64'd0);
    check("t5_rst_memsel", 64'(bus.mem_sel), 64'd0);
    check("t5_rst_start", 64'(bus.phase_start), 64'd0);
    check("t5_rst_key", 64'(bus.key), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse_go();
    check("t5_rst_go_sel", 64'(bus.mem_sel), 64'd0);

`ifdef PHASE_TIMEOUT_EN
    // 6: phase 1 never finishes
    auto_en    = 1'b0;
    man_finish = 4'b0001;
    do_reset();
    check("t6_rst_to", 64'(bus.timeout), 64'd0);
    pulse_go();
    wait_done(cyc, 100);
    check("t6_cycles", 64'(cyc), 64'd13);
    check("t6_timeout", 64'(bus.timeout), 64'd1);
    check("t6_err_phase", 64'(bus.err_phase), 64'd2);
    check("t6_found", 64'(bus.found), 64'd0);
    check("t6_exh", 64'(bus.exhausted), 64'd0);
    pulse_go();
    check("t6_to_clr", 64'(bus.timeout), 64'd0);
    check("t6_err_clr", 64'(bus.err_phase), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
